// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC stepping, branch redirect through the
// lookup table, run/stop control and a saturating cycle counter.
module pc_sequencer #(
  parameter int PC_W  = 8,
  parameter int KEY_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [KEY_W-1:0] br_key,
  input  logic             halt_instr,
  output logic [KEY_W-1:0] lut_key,
  input  logic [PC_W-1:0]  lut_addr,
  output logic [PC_W-1:0]  pc,
  output logic             instr_valid,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign running     = (state == RUN) || (state == FLUSH);
  assign done        = (state == DONE);
  assign instr_valid = (state == RUN) && !stall;
  assign lut_key     = (state == RUN) ? br_key : '0;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cycle_cnt;
    if (running && (cycle_cnt != '1)) begin
      cnt_nxt = cycle_cnt + 1'b1;
    end
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          pc_nxt    = start_addr;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // halt wins over a simultaneous taken branch
        if (!stall) begin
          if (halt_instr) begin
            state_nxt = DONE;
          end else if (br_taken) begin
            pc_nxt    = lut_addr;
            state_nxt = FLUSH;
          end else begin
            pc_nxt = pc + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      cycle_cnt <= cnt_nxt;
    end
  end

endmodule
